ps2_key_decoder: RTL

- Receives the raw PS/2 keyboard serial stream on ps2_clk/ps2_data and deserializes 11-bit frames.
- Folds the E0 (extended) and F0 (break) prefixes into the following code byte.
- Emits one toggle-strobed 11-bit key event word per key action.
- This block is the producer of the ps2_key bus consumed by the QL keyboard matrix block and the other keyboard consumers in the core.

---
 rtl/ps2_key_decoder_if.sv | 24 ++
 rtl/ps2_key_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard line and key-event bus shared by the decoder (master) and keyboard consumers (slave).
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output frame_err,
    output busy
  );

  modport slave (
    input ps2_clk,
    input ps2_data,
    input ps2_key,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw lines, deserializes frames, folds E0/F0 prefixes into toggle-strobed key events.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the same key until its break.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 11000
) (
  input  logic               clk,
  input  logic               delay_reset,
  ps2_key_decoder_if.master  bus
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]     FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [3:0]    flt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          par;
  logic [TW-1:0] tmo_cnt;
  logic          byte_rdy;
  logic          byte_ok;
  logic          ext_f, rel_f;
  logic [10:0]   key_q;
  logic          err_q;
  logic          busy_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]    last_make;
  logic          mk_valid;
`endif

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;

  // fall is registered at the moment the filtered clock commits to low
  always_ff @(posedge clk or posedge delay_reset) begin
    if (delay_reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      filt    <= 1'b1;
      flt_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 != filt) begin
        if (flt_cnt == FLT_LAST) begin
          filt    <= clk_s2;
          flt_cnt <= '0;
          fall    <= filt;
        end else begin
          flt_cnt <= flt_cnt + 4'd1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge delay_reset) begin
    if (delay_reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      par       <= 1'b0;
      tmo_cnt   <= '0;
      byte_rdy  <= 1'b0;
      byte_ok   <= 1'b0;
      ext_f     <= 1'b0;
      rel_f     <= 1'b0;
      key_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make <= '0;
      mk_valid  <= 1'b0;
`endif
    end else begin
      err_q    <= 1'b0;
      byte_rdy <= 1'b0;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fall) begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          // a fall in the same cycle as the timeout keeps the frame alive
          if (fall) begin
            tmo_cnt <= '0;
            case (state)
              DATA: begin
                sh <= {dat_s2, sh[7:1]};
                if (bit_cnt == 3'd7) state <= PARITY;
                else                 bit_cnt <= bit_cnt + 3'd1;
              end
              PARITY: begin
                par   <= dat_s2;
                state <= STOP;
              end
              default: begin
                byte_ok  <= dat_s2 & (^{sh, par});
                byte_rdy <= 1'b1;
                state    <= IDLE;
                busy_q   <= 1'b0;
              end
            endcase
          end else if (tmo_cnt == TMO_MAX) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            ext_f   <= 1'b0;
            rel_f   <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase

      if (byte_rdy) begin
        if (!byte_ok) begin
          err_q <= 1'b1;
          ext_f <= 1'b0;
          rel_f <= 1'b0;
        end else if (sh == 8'hE0) begin
          ext_f <= 1'b1;
        end else if (sh == 8'hF0) begin
          rel_f <= 1'b1;
        end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (rel_f) begin
            key_q    <= {~key_q[10], ~rel_f, ext_f, sh};
            mk_valid <= 1'b0;
          end else if (!(mk_valid && (last_make == {ext_f, sh}))) begin
            key_q     <= {~key_q[10], ~rel_f, ext_f, sh};
            last_make <= {ext_f, sh};
            mk_valid  <= 1'b1;
          end
`else
          key_q <= {~key_q[10], ~rel_f, ext_f, sh};
`endif
          ext_f <= 1'b0;
          rel_f <= 1'b0;
        end
      end
    end
  end

endmodule
